// File: rtl/register_file_if.sv
// Operand-fetch / writeback bus of the architectural register file.
// The datapath is the master, the register file is the slave.
interface register_file_if;
    logic        WE3;
    logic [3:0]  A1;
    logic [3:0]  A2;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [31:0] R15;
    logic [31:0] RD1;
    logic [31:0] RD2;

    modport master (
        output WE3, A1, A2, A3, WD3, R15,
        input  RD1, RD2
    );

    modport slave (
        input  WE3, A1, A2, A3, WD3, R15,
        output RD1, RD2
    );
endinterface

// File: rtl/register_file.sv
// 16-index register file: R0-R14 in flops, index 15 reads the datapath's PC+8.
// Two combinational read ports, one synchronous write port.
module register_file (
    input  logic             CLK,
    input  logic             RESET,
    register_file_if.slave   rf
);
    logic [31:0] regs [0:14];

    // Index 15 has no storage, so writes to it are dropped; reset wins over writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < 15; i++) begin
                regs[i[3:0]] <= '0;
            end
        end else if (rf.WE3 && (rf.A3 != 4'd15)) begin
            regs[rf.A3] <= rf.WD3;
        end
    end

    always_comb begin
        rf.RD1 = '0;
        rf.RD2 = '0;
        if (rf.A1 == 4'd15) rf.RD1 = rf.R15;
        else                rf.RD1 = regs[rf.A1];
        if (rf.A2 == 4'd15) rf.RD2 = rf.R15;
        else                rf.RD2 = regs[rf.A2];
    end
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    register_file_if bus ();

    register_file dut (
        .CLK   (CLK),
        .RESET (RESET),
        .rf    (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET = 1'b1;
        bus.WE3 = 1'b0;
        bus.A1 = '0;
        bus.A2 = '0;
        bus.A3 = '0;
        bus.WD3 = '0;
        bus.R15 = '0;

        // Reset clears R0-R14
        tick();
        RESET = 1'b0;
        for (int n = 0; n < 15; n++) begin
            bus.A1 = 4'(n);
            bus.A2 = 4'(14 - n);
            #1;
            check("reset_rd1", bus.RD1, 32'h0);
            check("reset_rd2", bus.RD2, 32'h0);
        end
        bus.A1 = 4'd15;
        bus.R15 = 32'h00000001;
        #1;
        check("reset_r15", bus.RD1, 32'h00000001);

        // Sequential writes n+1 -> Rn
        bus.WE3 = 1'b1;
        for (int n = 0; n < 15; n++) begin
            bus.A3 = 4'(n);
            bus.WD3 = 32'(n + 1);
            tick();
        end
        bus.WE3 = 1'b0;
        bus.R15 = 32'hCAFE0000;
        for (int n = 0; n < 15; n++) begin
            bus.A1 = 4'(n);
            bus.A2 = 4'(n + 1);
            #1;
            check("wr_rd1", bus.RD1, 32'(n + 1));
            check("wr_rd2", bus.RD2, (n == 14) ? 32'hCAFE0000 : 32'(n + 2));
        end

        // R15 passthrough while a write to index 15 is attempted
        bus.WE3 = 1'b1;
        bus.A3 = 4'd15;
        bus.WD3 = 32'hDEADBEEF;
        bus.A1 = 4'd15;
        for (int k = 1; k <= 5; k++) begin
            bus.R15 = 32'(k);
            #1;
            check("r15_follow", bus.RD1, 32'(k));
            tick();
        end
        bus.WE3 = 1'b0;
        for (int n = 0; n < 15; n++) begin
            bus.A2 = 4'(n);
            #1;
            check("r15_protect", bus.RD2, 32'(n + 1));
        end

        // WE3 low blocks writes
        bus.A3 = 4'd3;
        bus.WD3 = 32'hFFFFFFFF;
        tick();
        tick();
        tick();
        bus.A1 = 4'd3;
        #1;
        check("we_low", bus.RD1, 32'h00000004);

        // Read-during-write: old value before the edge, new after
        bus.WE3 = 1'b1;
        bus.A3 = 4'd5;
        bus.WD3 = 32'h00000011;
        tick();
        bus.A1 = 4'd5;
        bus.WD3 = 32'h00000022;
        #1;
        check("rdw_before", bus.RD1, 32'h00000011);
        tick();
        check("rdw_after", bus.RD1, 32'h00000022);
        bus.WE3 = 1'b0;

        // Reset priority over a concurrent write; R15 still visible during reset
        RESET = 1'b1;
        bus.WE3 = 1'b1;
        bus.A3 = 4'd7;
        bus.WD3 = 32'h12345678;
        bus.A2 = 4'd15;
        bus.R15 = 32'h0000ABCD;
        #1;
        check("rst_r15", bus.RD2, 32'h0000ABCD);
        tick();
        RESET = 1'b0;
        bus.WE3 = 1'b0;
        bus.A1 = 4'd7;
        bus.A2 = 4'd5;
        #1;
        check("rst_prio", bus.RD1, 32'h0);
        check("rst_clear", bus.RD2, 32'h0);

        // Writes resume after reset
        bus.WE3 = 1'b1;
        bus.WD3 = 32'h000000AA;
        tick();
        bus.WE3 = 1'b0;
        check("post_rst_wr", bus.RD1, 32'h000000AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
